sd_sector_writer: RTL and testbench

Flushes a contiguous run of 512-byte sectors from the on-chip SD sector buffer back to the SD card via the `sd_controller` byte-level write interface. It is the write-direction counterpart of the SD load path, which fills the buffer from the card. The block sits in the 25 MHz SD clock domain between the buffer's read port and `sd_controller`. It drives `wr`, `din` and `address`, and paces bytes on `ready_for_next_byte`.

---
 rtl/sd_sector_writer.sv | 123 ++++++++++++
 tb/tb_sd_sector_writer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_writer.sv
// Streams SECTORS consecutive 512-byte sectors from the SD sector buffer to sd_controller.
// Buffer words are sent big-endian, one byte per rising edge of sd_ready_for_next_byte.
module sd_sector_writer #(
  parameter int unsigned SECTORS = 16,
  parameter int unsigned BUF_AW  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       base_adr,
  output logic              busy,
  output logic              done,
  output logic [BUF_AW-1:0] buf_adr,
  input  logic [31:0]       buf_data,
  input  logic              sd_ready,
  input  logic              sd_ready_for_next_byte,
  output logic              sd_wr,
  output logic [7:0]        sd_din,
  output logic [31:0]       sd_address
);

  localparam int unsigned SecW = (SECTORS > 1) ? $clog2(SECTORS) : 1;
  localparam logic [SecW-1:0] LastSec = SecW'(SECTORS - 1);

  typedef enum logic [2:0] {
    StIdle, StIssue, StWaitAccept, StStream, StWaitDone, StDone
  } state_e;

  state_e          state_q;
  logic [SecW-1:0] sector_idx_q;
  logic [6:0]      word_idx_q;
  logic [1:0]      byte_idx_q;
  logic [8:0]      byte_cnt_q;
  logic            rfnb_q;
  logic            byte_edge;

  assign byte_edge = sd_ready_for_next_byte & ~rfnb_q;
  assign buf_adr   = BUF_AW'({sector_idx_q, word_idx_q});

  always_comb begin
    sd_din = buf_data[31:24];
    unique case (byte_idx_q)
      2'd0: sd_din = buf_data[31:24];
      2'd1: sd_din = buf_data[23:16];
      2'd2: sd_din = buf_data[15:8];
      2'd3: sd_din = buf_data[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      busy         <= 1'b0;
      done         <= 1'b0;
      sd_wr        <= 1'b0;
      sd_address   <= '0;
      sector_idx_q <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      byte_cnt_q   <= '0;
      rfnb_q       <= 1'b0;
    end else begin
      rfnb_q <= sd_ready_for_next_byte;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sd_address <= base_adr;
            busy       <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          if (sd_ready) begin
            sd_wr   <= 1'b1;
            state_q <= StWaitAccept;
          end
        end
        StWaitAccept: begin
          if (!sd_ready) begin
            sd_wr      <= 1'b0;
            byte_idx_q <= '0;
            byte_cnt_q <= '0;
            state_q    <= StStream;
          end
        end
        StStream: begin
          if (byte_edge) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            byte_cnt_q <= byte_cnt_q + 9'd1;
            // Last byte keeps word_idx at 127; WAIT_DONE rewinds it for the next sector.
            if (byte_cnt_q == 9'd511) begin
              state_q <= StWaitDone;
            end else if (byte_idx_q == 2'd3) begin
              word_idx_q <= word_idx_q + 7'd1;
            end
          end
        end
        StWaitDone: begin
          if (sd_ready) begin
            if (sector_idx_q == LastSec) begin
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              sector_idx_q <= sector_idx_q + 1'b1;
              word_idx_q   <= '0;
              sd_address   <= sd_address + 32'd512;
              state_q      <= StIssue;
            end
          end
        end
        StDone: begin
          done         <= 1'b0;
          busy         <= 1'b0;
          sector_idx_q <= '0;
          word_idx_q   <= '0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_sector_writer.sv
// Bench for sd_sector_writer: a 16-sector and a 1-sector instance share one sd_controller
// model that checks write addresses and every streamed byte against a scoreboard.
module tb_sd_sector_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start16 = 1'b0, start1 = 1'b0;
  logic [31:0] base_adr = '0;
  logic [31:0] mem [0:2047];

  logic        busy16, done16, wr16, busy1, done1, wr1;
  logic [10:0] adr16, adr1;
  logic [7:0]  din16, din1;
  logic [31:0] addr16, addr1, bd16, bd1;

  logic m_ready = 1'b1, hold_low = 1'b0, rfnb = 1'b0, sel = 1'b0;
  wire  sd_ready = m_ready & ~hold_low;
  wire         m_wr   = sel ? wr1 : wr16;
  wire  [7:0]  m_din  = sel ? din1 : din16;
  wire  [31:0] m_addr = sel ? addr1 : addr16;
  wire  [10:0] m_adr  = sel ? adr1 : adr16;

  int gap = 1, hold = 1, post = 2;
  int n_cmp = 0, n_fail = 0;
  int sec_seen = 0, byte_no = 0;
  logic [10:0] last_adr = '0;
  logic [7:0]  fb [0:3];
  logic [31:0] exp_addr [$];
  logic [7:0]  exp_byte [$];
  int nwr16 = 0, nwr1 = 0, ndone16 = 0, ndone1 = 0;
  logic wr16_q = 1'b0, wr1_q = 1'b0;

  assign bd16 = mem[adr16];
  assign bd1  = mem[adr1];

  always #5 clk = ~clk;

  sd_sector_writer #(.SECTORS(16), .BUF_AW(11)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .base_adr(base_adr), .busy(busy16),
    .done(done16), .buf_adr(adr16), .buf_data(bd16), .sd_ready(sd_ready),
    .sd_ready_for_next_byte(rfnb), .sd_wr(wr16), .sd_din(din16), .sd_address(addr16)
  );

  sd_sector_writer #(.SECTORS(1), .BUF_AW(11)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .base_adr(base_adr), .busy(busy1),
    .done(done1), .buf_adr(adr1), .buf_data(bd1), .sd_ready(sd_ready),
    .sd_ready_for_next_byte(rfnb), .sd_wr(wr1), .sd_din(din1), .sd_address(addr1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_flush(input logic [31:0] base, input int nsec);
    logic [31:0] d;
    for (int s = 0; s < nsec; s++) begin
      exp_addr.push_back(base + 32'(s) * 32'd512);
      for (int w = 0; w < 128; w++) begin
        d = mem[s * 128 + w];
        for (int k = 0; k < 4; k++) exp_byte.push_back(d[31 - 8 * k -: 8]);
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (!(sel ? done1 : done16) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("done_timeout", 32'(c >= budget), 32'd0);
  endtask

  task automatic wait_bytes(input int sec_rel, input int s0, input int n, input int budget);
    int c = 0;
    while (!((sec_seen - s0) == sec_rel && byte_no >= n) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("byte_wait_timeout", 32'(c >= budget), 32'd0);
  endtask

  // Controller model: latches din before each ready_for_next_byte rising edge.
  initial begin : ctrl_model
    logic [31:0] ea;
    logic [7:0]  eb;
    forever begin
      @(negedge clk);
      if (!reset && m_wr && sd_ready) begin
        ea = (exp_addr.size() > 0) ? exp_addr.pop_front() : 32'hxxxx_xxxx;
        chk("cmd_addr", m_addr, ea);
        m_ready = 1'b0;
        byte_no = 0;
        for (int b = 0; b < 512 && !reset; b++) begin
          repeat (gap) @(negedge clk);
          if (reset) break;
          eb = (exp_byte.size() > 0) ? exp_byte.pop_front() : 8'hxx;
          chk("din", 32'(m_din), 32'(eb));
          chk("wr_in_stream", 32'(m_wr), 32'd0);
          if (b < 4) fb[b] = m_din;
          if (b == 511) last_adr = m_adr;
          byte_no = b + 1;
          rfnb = 1'b1;
          repeat (hold) @(negedge clk);
          rfnb = 1'b0;
        end
        for (int i = 0; i < post && !reset; i++) begin
          @(negedge clk);
          chk("wr_in_wait_done", 32'(m_wr), 32'd0);
        end
        rfnb = 1'b0;
        m_ready = 1'b1;
        byte_no = 0;
        sec_seen++;
      end
    end
  end

  always @(negedge clk) begin
    wr16_q <= wr16;
    wr1_q  <= wr1;
    if (wr16 && !wr16_q) nwr16 <= nwr16 + 1;
    if (wr1 && !wr1_q) nwr1 <= nwr1 + 1;
    if (done16) ndone16 <= ndone16 + 1;
    if (done1) ndone1 <= ndone1 + 1;
  end

  initial begin : main
    int w0, d0, s0;
    logic wr_seen;
    for (int i = 0; i < 2048; i++) mem[i] = 32'(i);
    mem[0] = 32'hA500_0000;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy16), 32'd0);
    chk("rst_done", 32'(done16), 32'd0);
    chk("rst_wr", 32'(wr16), 32'd0);
    chk("rst_addr", addr16, 32'd0);
    chk("rst_buf_adr", 32'(adr16), 32'd0);
    chk("rst_din", 32'(din16), 32'hA5);
    mem[0] = 32'd0;
    reset = 1'b0;
    @(negedge clk);

    // Basic 16-sector flush, one byte every 8 cycles
    sel = 1'b0; gap = 7; hold = 1; post = 2;
    push_flush(32'd0, 16);
    w0 = nwr16; d0 = ndone16;
    base_adr = 32'd0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    chk("start_busy", 32'(busy16), 32'd1);
    chk("start_wr_early", 32'(wr16), 32'd0);
    @(negedge clk);
    chk("start_wr", 32'(wr16), 32'd1);
    wait_done(70000);
    repeat (3) @(negedge clk);
    chk("basic_wr_pulses", 32'(nwr16 - w0), 32'd16);
    chk("basic_done_pulses", 32'(ndone16 - d0), 32'd1);
    chk("basic_bytes_left", 32'(exp_byte.size()), 32'd0);
    chk("basic_cmds_left", 32'(exp_addr.size()), 32'd0);
    chk("basic_busy_after", 32'(busy16), 32'd0);

    // SECTORS=1 at 0x400 with a big-endian marker word
    mem[0] = 32'h1234_5678;
    sel = 1'b1; gap = 1; hold = 1; post = 3;
    push_flush(32'h400, 1);
    w0 = nwr1; d0 = ndone1;
    base_adr = 32'h400; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(3000);
    repeat (3) @(negedge clk);
    chk("order_b0", 32'(fb[0]), 32'h12);
    chk("order_b1", 32'(fb[1]), 32'h34);
    chk("order_b2", 32'(fb[2]), 32'h56);
    chk("order_b3", 32'(fb[3]), 32'h78);
    chk("one_last_buf_adr", 32'(last_adr), 32'd127);
    chk("one_wr_pulses", 32'(nwr1 - w0), 32'd1);
    chk("one_done_pulses", 32'(ndone1 - d0), 32'd1);
    chk("one_bytes_left", 32'(exp_byte.size()), 32'd0);

    // Handshake robustness: 3-cycle high level per byte, 50-cycle ready gap
    gap = 2; hold = 3; post = 50;
    push_flush(32'h800, 1);
    w0 = nwr1; d0 = ndone1;
    base_adr = 32'h800; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(5000);
    repeat (3) @(negedge clk);
    chk("robust_wr_pulses", 32'(nwr1 - w0), 32'd1);
    chk("robust_done_pulses", 32'(ndone1 - d0), 32'd1);
    chk("robust_bytes_left", 32'(exp_byte.size()), 32'd0);

    // Start with controller not ready, then start pulses during the flush
    gap = 1; hold = 1; post = 2;
    hold_low = 1'b1;
    push_flush(32'hC00, 1);
    w0 = nwr1; d0 = ndone1; s0 = sec_seen;
    base_adr = 32'hC00; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("notready_busy", 32'(busy1), 32'd1);
    wr_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      wr_seen |= wr1;
    end
    chk("notready_wr_held", 32'(wr_seen), 32'd0);
    hold_low = 1'b0;
    wait_bytes(0, s0, 100, 500);
    for (int i = 0; i < 3; i++) begin
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (50) @(negedge clk);
    end
    wait_done(3000);
    repeat (10) @(negedge clk);
    chk("busystart_wr_pulses", 32'(nwr1 - w0), 32'd1);
    chk("busystart_done_pulses", 32'(ndone1 - d0), 32'd1);
    chk("busystart_idle_busy", 32'(busy1), 32'd0);
    chk("busystart_bytes_left", 32'(exp_byte.size()), 32'd0);

    // Reset at byte 200 of sector 3
    sel = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 32'(i) ^ 32'hA5C3_0000;
    push_flush(32'h1_0000, 16);
    s0 = sec_seen;
    base_adr = 32'h1_0000; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    wait_bytes(3, s0, 200, 8000);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy16), 32'd0);
    chk("midrst_wr", 32'(wr16), 32'd0);
    chk("midrst_buf_adr", 32'(adr16), 32'd0);
    chk("midrst_addr", addr16, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_addr.delete();
    exp_byte.delete();
    repeat (2) @(negedge clk);

    // Fresh start must begin again at sector 0
    push_flush(32'h2_0000, 16);
    base_adr = 32'h2_0000; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    wait_bytes(0, sec_seen, 8, 200);
    chk("restart_addr", addr16, 32'h2_0000);
    chk("restart_buf_adr_sector", 32'(adr16 >> 7), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_addr.delete();
    exp_byte.delete();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
